ps2_rx_fifo: RTL

Parametrised PS/2-style serial receiver; successor to the single-byte receiver.
- Synchronises and glitch-filters the device clock (scl) and data (sda) into the ck domain.
- Frames start/data/parity/stop with a configurable data width and parity mode, and enforces an inter-edge timeout.
- Pushes good words into a show-ahead FIFO read by the host-side logic; framing, parity and overflow errors are reported as one-cycle pulses.

---
 rtl/ps2_rx_fifo.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo - PS/2-style serial receiver with a show-ahead word FIFO.
//
// The device clock (scl) and data (sda) are synchronised into the ck
// domain. scl is glitch-filtered, and each frame is assembled on falling
// edges of the filtered scl. A frame is start(0), DATA_BITS data bits LSB
// first, an optional odd/even parity bit, and stop(1). Good words are pushed
// into a FIFO. Framing, parity and overflow errors appear as one-cycle pulses.
//
// Ports
//   ck          in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   scl, sda    in   device clock / data, asynchronous to ck
//   rd_en       in   pop the head word (ignored while empty)
//   data_out    out  head word, valid while data_valid=1 (zero otherwise)
//   data_valid  out  FIFO not empty
//   fifo_full   out  FIFO holds FIFO_DEPTH words
//   fifo_level  out  number of words held
//   parity_err  out  pulse: frame dropped on parity mismatch
//   frame_err   out  pulse: bad stop bit or inter-edge timeout
//   overflow    out  pulse: good word dropped because the FIFO was full
module ps2_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          scl,
    input  logic                          sda,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          data_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    // Parity check helper: 1 when the received parity bit matches the mode.
    function automatic logic par_pass(input logic [DATA_BITS-1:0] d, input logic p);
        logic r;
        case (PARITY_MODE)
            1:       r = (^d) ^ p;
            2:       r = ~((^d) ^ p);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic                 scl_meta_q, scl_sync_q, sda_meta_q, sda_sync_q;
    logic                 scl_filt_q, fall_stb_q;
    logic [FW-1:0]        filt_cnt_q;
    state_e               state_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic [TW-1:0]        to_cnt_q;
    logic                 frame_err_q, parity_err_q, overflow_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        count_q;
    logic                 push_s, pop_s, wr_en_s, ovf_s;

    // Two-flop synchronisers; both lines reset to their idle-high level.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
        end
    end

    // scl glitch filter: the filtered level follows only after FILTER_LEN
    // consecutive differing samples; a falling change emits fall_stb.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            scl_filt_q <= 1'b1;
            filt_cnt_q <= {FW{1'b0}};
            fall_stb_q <= 1'b0;
        end else if (scl_sync_q != scl_filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                scl_filt_q <= scl_sync_q;
                filt_cnt_q <= {FW{1'b0}};
                fall_stb_q <= ~scl_sync_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FILT_ONE;
                fall_stb_q <= 1'b0;
            end
        end else begin
            filt_cnt_q <= {FW{1'b0}};
            fall_stb_q <= 1'b0;
        end
    end

    // Frame FSM with inter-edge timeout and registered error pulses.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= {IW{1'b0}};
            data_q       <= {DATA_BITS{1'b0}};
            par_q        <= 1'b0;
            to_cnt_q     <= {TW{1'b0}};
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (fall_stb_q) begin
                to_cnt_q <= {TW{1'b0}};
                case (state_q)
                    ST_IDLE: begin
                        // sda=1 here is a false start and is silently ignored
                        if (!sda_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= {IW{1'b0}};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        data_q[bit_idx_q] <= sda_sync_q;
                        if (bit_idx_q == IDX_LAST) begin
                            state_q <= (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_ONE;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= sda_sync_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        // a bad stop bit masks any parity failure
                        if (!sda_sync_q) begin
                            frame_err_q <= 1'b1;
                        end else if (!par_pass(data_q, par_q)) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b0;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (to_cnt_q == TO_LIMIT) begin
                    state_q     <= ST_IDLE;
                    frame_err_q <= 1'b1;
                    to_cnt_q    <= {TW{1'b0}};
                end else begin
                    to_cnt_q <= to_cnt_q + TO_ONE;
                end
            end else begin
                to_cnt_q <= {TW{1'b0}};
            end
        end
    end

    // Push/pop decisions; a pop frees the slot needed by a same-cycle push.
    always_comb begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        wr_en_s = 1'b0;
        ovf_s   = 1'b0;
        if (fall_stb_q && (state_q == ST_STOP) && sda_sync_q && par_pass(data_q, par_q)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s   = rd_en && (count_q != {LW{1'b0}});
        wr_en_s = push_s && ((count_q != LVL_FULL) || pop_s);
        ovf_s   = push_s && (count_q == LVL_FULL) && !pop_s;
    end

    // FIFO storage; contents are qualified by count_q, so no reset needed.
    always_ff @(posedge ck) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_q;
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= ovf_s;
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_q <= count_q + LVL_ONE;
                2'b01:   count_q <= count_q - LVL_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_valid = (count_q != {LW{1'b0}});
    assign fifo_full  = (count_q == LVL_FULL);
    assign fifo_level = count_q;
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : {DATA_BITS{1'b0}};
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
